// File: rtl/mem_arb_pkg.sv
// Shared encodings and sizing helpers for the IF/MA memory arbiter.
// The starvation-counter width is derived from the largest count it must hold.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MA = 1'b1
    } owner_e;

    function automatic int starve_w(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_W       = starve_w(STARVE_MAX_DEF);

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts MA grants made while IF is waiting; force_if requests one IF grant at the limit.
// Exists only in builds with MEM_ARB_FAIR_EN defined.
`ifdef MEM_ARB_FAIR_EN
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_grant_ma,
    input  logic i_grant_if,
    input  logic i_if_req,
    output logic o_force_if
);

    localparam int W = starve_w(STARVE_MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_grant_if) begin
            r_cnt <= '0;
        end else if (i_grant_ma && i_if_req && !o_force_if) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_force_if = (r_cnt == W'(STARVE_MAX));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between IF fetches and MA loads/stores (issue, wait, complete).
// Define MEM_ARB_FAIR_EN to bound IF starvation under continuous MA traffic.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              ma_req,
    input  logic              ma_wr,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              ma_done,
    output logic              ma_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              err
);

    state_e            r_state, w_next;
    owner_e            r_owner;
    logic              r_cancel, r_err, r_mem_en, r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_grant_if, w_grant_ma, w_accept, w_drop;
    logic              w_fin, w_force_if, w_if_ok, w_err_evt;

`ifdef MEM_ARB_FAIR_EN
    mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_grant_ma (w_grant_ma),
        .i_grant_if (w_grant_if),
        .i_if_req   (if_req),
        .o_force_if (w_force_if)
    );
`else
    logic w_unused_starve;
    assign w_force_if      = 1'b0;
    assign w_unused_starve = (STARVE_MAX == 0);
`endif

    assign w_if_ok = if_req & ~if_cancel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_grant_if = 1'b0;
        w_grant_ma = 1'b0;
        w_accept   = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_if_ok && (w_force_if || !ma_req)) w_grant_if = 1'b1;
                else if (ma_req)                        w_grant_ma = 1'b1;
                if (w_grant_if || w_grant_ma) w_next = ISSUE;
            end
            ISSUE: begin
                w_accept = r_mem_en & ~mem_busy;
                // A cancel can only retract a request the memory has not taken yet;
                // one accepted in the same cycle is drained through WAIT with done suppressed.
                if (r_owner == OWN_IF && if_cancel && !w_accept) begin
                    w_drop = 1'b1;
                    w_next = IDLE;
                end else if (w_accept) begin
                    w_next = WAIT;
                end
            end
            WAIT:    if (mem_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_fin     = (r_state == WAIT) & mem_done;
    assign w_err_evt = (mem_done & ((r_state == IDLE) | (r_state == ISSUE)))
                     | ((r_state != IDLE) & (r_owner == OWN_MA) & ~ma_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= OWN_IF;
            r_cancel    <= 1'b0;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_err_evt) r_err <= 1'b1;
            if (w_grant_ma || w_grant_if) begin
                r_owner     <= w_grant_ma ? OWN_MA : OWN_IF;
                r_mem_en    <= 1'b1;
                r_mem_wr    <= w_grant_ma & ma_wr;
                r_mem_addr  <= w_grant_ma ? ma_addr : if_addr;
                r_mem_wdata <= w_grant_ma ? ma_wdata : '0;
            end else if (w_accept || w_drop) begin
                r_mem_en <= 1'b0;
            end
            if (w_next == IDLE)
                r_cancel <= 1'b0;
            else if (r_owner == OWN_IF && if_cancel && (r_state == WAIT || w_accept))
                r_cancel <= 1'b1;
        end
    end

    // Completion is a same-cycle pass-through of the memory's done and data.
    assign if_done   = w_fin & (r_owner == OWN_IF) & ~r_cancel & ~if_cancel;
    assign ma_done   = w_fin & (r_owner == OWN_MA);
    assign if_rdata  = if_done ? mem_rdata : '0;
    assign ma_rdata  = ma_done ? mem_rdata : '0;
    assign if_stall  = if_req & ~if_done;
    assign ma_stall  = ma_req & ~ma_done;
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule
